// File: rtl/pll_lock_sequencer_pkg.sv
// Shared types and default constants for the PLL lock supervisor and its helpers.
package pll_seq_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } pll_state_e;

  localparam int DEF_PLL_RST_CYCLES = 16;
  localparam int DEF_STABLE_CYCLES  = 1024;
  localparam int DEF_TIMEOUT_CYCLES = 65536;
  localparam int DEF_CNT_W          = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// Single-bit two-flop synchronizer for asynchronous inputs (lock, encoder, fault pins).
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_p0;
  logic sync_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      meta_p0 <= d;
      sync_p1 <= meta_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Drives the PLL reset, qualifies lock over a stable window and releases the system reset.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_lock,
  input  logic             clr_stat,
  output logic             pll_reset,
  output logic             sys_rst_n,
  output logic             ready,
  output logic [CNT_W-1:0] loss_count,
  output logic             timeout_err
);

  // The timer holds (cycles - 1), so it must fit the largest of the three windows.
  localparam int TMR_MAX = max3(PLL_RST_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] LD_RST     = TMR_W'(PLL_RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] LD_STABLE  = TMR_W'(STABLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] LD_TIMEOUT = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  pll_state_e       state;
  pll_state_e       state_next;
  logic [TMR_W-1:0] tmr;
  logic [TMR_W-1:0] tmr_next;
  logic             lock_s;
  logic             loss_evt;
  logic             timeout_evt;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  always_comb begin
    state_next  = state;
    tmr_next    = tmr;
    loss_evt    = 1'b0;
    timeout_evt = 1'b0;
    case (state)
      PLL_RST: begin
        if (tmr == '0) begin
          state_next = WAIT_LOCK;
          tmr_next   = LD_TIMEOUT;
        end else begin
          tmr_next = tmr - TMR_ONE;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_next = STABLE;
          tmr_next   = LD_STABLE;
        end else if (tmr == '0) begin
          timeout_evt = 1'b1;
          state_next  = PLL_RST;
          tmr_next    = LD_RST;
        end else begin
          tmr_next = tmr - TMR_ONE;
        end
      end
      STABLE: begin
        // A dropout here is treated as a glitch: retry the lock wait, no loss count.
        if (!lock_s) begin
          state_next = WAIT_LOCK;
          tmr_next   = LD_TIMEOUT;
        end else if (tmr == '0) begin
          state_next = RUN;
        end else begin
          tmr_next = tmr - TMR_ONE;
        end
      end
      RUN: begin
        if (!lock_s) begin
          loss_evt   = 1'b1;
          state_next = PLL_RST;
          tmr_next   = LD_RST;
        end
      end
      default: begin
        state_next = PLL_RST;
        tmr_next   = LD_RST;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= PLL_RST;
      tmr   <= LD_RST;
    end else begin
      state <= state_next;
      tmr   <= tmr_next;
    end
  end

  // Outputs decode the next state so they line up with the state register, glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pll_reset <= 1'b1;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
    end else begin
      pll_reset <= (state_next == PLL_RST);
      sys_rst_n <= (state_next == RUN);
      ready     <= (state_next == RUN);
    end
  end

  // A new event takes priority over a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loss_count  <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (loss_evt) begin
        if (clr_stat) begin
          loss_count <= CNT_ONE;
        end else if (loss_count != CNT_MAX) begin
          loss_count <= loss_count + CNT_ONE;
        end
      end else if (clr_stat) begin
        loss_count <= '0;
      end

      if (timeout_evt) begin
        timeout_err <= 1'b1;
      end else if (clr_stat) begin
        timeout_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench: a phase-level reference model predicts outputs each cycle; a monitor compares.
module tb_pll_lock_sequencer;

  localparam int P     = 4;
  localparam int S     = 8;
  localparam int T     = 64;
  localparam int CW    = 4;
  localparam int LMAX  = (1 << CW) - 1;

  localparam int PH_RST    = 0;
  localparam int PH_WAIT   = 1;
  localparam int PH_STABLE = 2;
  localparam int PH_RUN    = 3;

  typedef struct packed {
    logic          pll_reset;
    logic          sys_rst_n;
    logic          ready;
    logic [CW-1:0] loss;
    logic          terr;
  } obs_t;

  logic          clk;
  logic          rst_n;
  logic          pll_lock;
  logic          clr_stat;
  logic          pll_reset;
  logic          sys_rst_n;
  logic          ready;
  logic [CW-1:0] loss_count;
  logic          timeout_err;

  int   errors;
  int   checks;
  obs_t exp_q[$];

  // Reference model state, in phase / elapsed-cycle terms.
  int   ph;
  int   el;
  int   m_loss;
  bit   m_terr;
  bit   done;

  pll_lock_sequencer #(
    .PLL_RST_CYCLES (P),
    .STABLE_CYCLES  (S),
    .TIMEOUT_CYCLES (T),
    .CNT_W          (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_lock    (pll_lock),
    .clr_stat    (clr_stat),
    .pll_reset   (pll_reset),
    .sys_rst_n   (sys_rst_n),
    .ready       (ready),
    .loss_count  (loss_count),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: lock is seen two edges after it is sampled; rules applied per edge.
  initial begin
    bit h1, h2, ls, ev_loss, ev_to;
    obs_t e;
    ph = PH_RST; el = 0; m_loss = 0; m_terr = 0; h1 = 0; h2 = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        ph = PH_RST; el = 0; m_loss = 0; m_terr = 0; h1 = 0; h2 = 0;
      end else begin
        ls = h2; h2 = h1; h1 = pll_lock;
        ev_loss = 0; ev_to = 0;
        case (ph)
          PH_RST: begin
            el++;
            if (el == P) begin ph = PH_WAIT; el = 0; end
          end
          PH_WAIT: begin
            if (ls) begin ph = PH_STABLE; el = 0; end
            else begin
              el++;
              if (el == T) begin ev_to = 1; ph = PH_RST; el = 0; end
            end
          end
          PH_STABLE: begin
            if (!ls) begin ph = PH_WAIT; el = 0; end
            else begin
              el++;
              if (el == S) begin ph = PH_RUN; el = 0; end
            end
          end
          default: begin
            if (!ls) begin ev_loss = 1; ph = PH_RST; el = 0; end
          end
        endcase
        if (ev_loss) m_loss = clr_stat ? 1 : ((m_loss == LMAX) ? LMAX : m_loss + 1);
        else if (clr_stat) m_loss = 0;
        if (ev_to) m_terr = 1;
        else if (clr_stat) m_terr = 0;
      end
      e.pll_reset = (ph == PH_RST);
      e.sys_rst_n = (ph == PH_RUN);
      e.ready     = (ph == PH_RUN);
      e.loss      = CW'(m_loss);
      e.terr      = m_terr;
      exp_q.push_back(e);
    end
  end

  // Monitor: every clock the DUT presents a full output set; compare on the falling edge.
  initial begin
    obs_t a, e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{pll_reset, sys_rst_n, ready, loss_count, timeout_err};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs @%0t: got rst=%b sys=%b rdy=%b loss=%0d terr=%b, want rst=%b sys=%b rdy=%b loss=%0d terr=%b",
                   $time, a.pll_reset, a.sys_rst_n, a.ready, a.loss, a.terr,
                   e.pll_reset, e.sys_rst_n, e.ready, e.loss, e.terr);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  task automatic wait_model(input int p, input int e, input int budget, input string tag);
    int k;
    k = 0;
    while (!(ph == p && el == e) && k < budget) begin
      step(1);
      k++;
    end
    if (!(ph == p && el == e)) begin
      checks++;
      errors++;
      $display("FAIL %s: phase %0d/%0d not reached in %0d cycles, at %0d/%0d", tag, p, e, budget, ph, el);
    end
  endtask

  initial begin
    errors = 0; checks = 0; done = 0;
    rst_n = 1'b1; pll_lock = 1'b0; clr_stat = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_pll_reset", int'(pll_reset), 1);
    chk("reset_sys_rst_n", int'(sys_rst_n), 0);
    step(3);
    rst_n = 1'b1;

    // Nominal start-up.
    step(9);
    pll_lock = 1'b1;
    wait_model(PH_RUN, 0, 100, "nominal_run");
    step(20);
    chk("nominal_loss", int'(loss_count), 0);

    // Repeated losses in RUN, saturating.
    for (int i = 0; i < 17; i++) begin
      pll_lock = 1'b0;
      step(3);
      pll_lock = 1'b1;
      wait_model(PH_RUN, 0, 100, "loss_relock");
      step(2);
    end
    chk("loss_saturated", int'(loss_count), LMAX);

    // Clear coincident with a RUN loss.
    pll_lock = 1'b0;
    step(2);
    clr_stat = 1'b1;
    step(1);
    clr_stat = 1'b0;
    chk("clr_with_loss", int'(loss_count), 1);

    // Timeout, clear, then clear coincident with a second timeout.
    wait_model(PH_WAIT, T - 1, 200, "timeout_wait");
    step(1);
    chk("timeout_set", int'(timeout_err), 1);
    chk("timeout_pll_reset", int'(pll_reset), 1);
    step(2);
    clr_stat = 1'b1;
    step(1);
    clr_stat = 1'b0;
    chk("timeout_cleared", int'(timeout_err), 0);
    wait_model(PH_WAIT, T - 1, 200, "timeout_wait2");
    clr_stat = 1'b1;
    step(1);
    clr_stat = 1'b0;
    chk("clr_with_timeout", int'(timeout_err), 1);
    pll_lock = 1'b1;
    wait_model(PH_RUN, 0, 100, "relock_run");
    step(3);

    // Asynchronous reset off the clock edge while in RUN.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_sys_rst_n", int'(sys_rst_n), 0);
    chk("async_ready", int'(ready), 0);
    chk("async_pll_reset", int'(pll_reset), 1);
    chk("async_loss", int'(loss_count), 0);
    chk("async_terr", int'(timeout_err), 0);
    step(2);
    pll_lock = 1'b0;
    rst_n = 1'b1;

    // Glitch five cycles into STABLE.
    step(9);
    pll_lock = 1'b1;
    wait_model(PH_STABLE, 5, 50, "glitch_stable");
    pll_lock = 1'b0;
    step(2);
    pll_lock = 1'b1;
    wait_model(PH_RUN, 0, 100, "glitch_run");
    step(2);
    chk("glitch_loss", int'(loss_count), 0);

    // Randomized lock waveform with sporadic clears.
    for (int seg = 0; seg < 60; seg++) begin
      int len;
      pll_lock = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(60, 90)) : int'($urandom_range(1, 30));
      for (int c = 0; c < len; c++) begin
        clr_stat = ($urandom_range(0, 15) == 0);
        step(1);
      end
      clr_stat = 1'b0;
    end

    step(3);
    done = 1;
    @(negedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
